huffman_translation_arbiter: RTL

- Shares one huffman_translation pipeline among NUM_REQ literal/match requesters, e.g. parallel LZ77 lanes.
- Arbitrates round-robin and issues at most one (l_V, d_V) pair per cycle.
- Tracks lane tags through the fixed-latency pipeline and buffers results in a tagged output FIFO.
- Uses credit-based issue, so results are never dropped when the downstream consumer stalls.

---
 rtl/huffman_translation_arbiter.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/huffman_translation_arbiter.sv
// Round-robin, credit-gated front end sharing one huffman_translation pipeline among NUM_REQ lanes.
// Define HUFF_ARB_STALL_CNT_EN to add the saturating stall_cnt output.

module huffman_translation_arbiter_chk (
   input logic clk,
   input logic reset,
   input logic mem_wr,
   input logic mem_full
);
   // Credits must make a write into a full result buffer impossible.
   always @(posedge clk) begin
      if (!reset) begin
         assert (!(mem_wr && mem_full)) else $error("result FIFO overflow");
      end
   end
endmodule

module huffman_translation_arbiter #(
   parameter int  NUM_REQ    = 4,
   parameter int  FIFO_DEPTH = 8,
   parameter int  PIPE_LAT   = 3,
   localparam int TAG_W      = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_l_V,
   input  logic [16*NUM_REQ-1:0]  req_d_V,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   tr_enable,
   output logic [7:0]             tr_l_V,
   output logic [15:0]            tr_d_V,
   input  logic [55:0]            tr_result,
   input  logic                   tr_output_ready,
   output logic                   out_valid,
   output logic [TAG_W-1:0]       out_tag,
   output logic [55:0]            out_data,
   input  logic                   out_ready,
   output logic                   tag_error
`ifdef HUFF_ARB_STALL_CNT_EN
   ,
   output logic [31:0]            stall_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int EW = TAG_W + 56;

   logic               can_issue_s;
   logic               issue_s;
   logic [NUM_REQ-1:0] grant_s;
   logic [TAG_W-1:0]   grant_idx_s;
   logic               pop_s;
   logic               load_s;
   logic               mem_empty_s;
   logic               mem_full_s;
   logic               mem_wr_s;
   logic               mem_rd_s;
   logic [EW-1:0]      wr_word_s;

   logic [CW-1:0]      credits_q, credits_d;
   logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               tr_enable_q, tr_enable_d;
   logic [7:0]         tr_l_v_q, tr_l_v_d;
   logic [15:0]        tr_d_v_q, tr_d_v_d;
   logic [TAG_W-1:0]   issue_tag_q, issue_tag_d;
   logic [PIPE_LAT-1:0] pipe_vld_q, pipe_vld_d;
   logic [TAG_W-1:0]   pipe_tag_q [PIPE_LAT];
   logic [TAG_W-1:0]   pipe_tag_d [PIPE_LAT];
   logic [EW-1:0]      mem_q [FIFO_DEPTH];
   logic [EW-1:0]      mem_d [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]        count_q, count_d;
   logic               out_valid_q, out_valid_d;
   logic [TAG_W-1:0]   out_tag_q, out_tag_d;
   logic [55:0]        out_data_q, out_data_d;
   logic               tag_error_q, tag_error_d;

   assign can_issue_s = (credits_q < CW'(FIFO_DEPTH));

   // Round-robin scan from rr_ptr; no grant while out of credits or in reset.
   always_comb begin
      int  scan_idx_s;
      logic hit_s;
      grant_s     = '0;
      grant_idx_s = '0;
      issue_s     = 1'b0;
      scan_idx_s  = 0;
      hit_s       = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx_s          = (int'(rr_ptr_q) + k) % NUM_REQ;
         hit_s               = can_issue_s && !reset && !issue_s && req_valid[scan_idx_s];
         grant_s[scan_idx_s] = hit_s;
         grant_idx_s         = hit_s ? TAG_W'(scan_idx_s) : grant_idx_s;
         issue_s             = issue_s | hit_s;
      end
   end

   // Issue register, pointer and credit bookkeeping.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      tr_enable_d = issue_s;
      tr_l_v_d    = tr_l_v_q;
      tr_d_v_d    = tr_d_v_q;
      issue_tag_d = issue_tag_q;
      if (issue_s) begin
         rr_ptr_d    = (grant_idx_s == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + TAG_W'(1'b1);
         tr_l_v_d    = req_l_V[int'(grant_idx_s)*8 +: 8];
         tr_d_v_d    = req_d_V[int'(grant_idx_s)*16 +: 16];
         issue_tag_d = grant_idx_s;
      end else begin
         rr_ptr_d    = rr_ptr_q;
      end
      credits_d = credits_q + CW'(issue_s) - CW'(pop_s);
   end

   // Tag pipe mirrors the translator latency so each result returns with its lane.
   always_comb begin
      pipe_vld_d[0] = tr_enable_q;
      pipe_tag_d[0] = issue_tag_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         pipe_tag_d[i] = pipe_tag_q[i-1];
      end
      tag_error_d = tag_error_q | (tr_output_ready != pipe_vld_q[PIPE_LAT-1]);
   end

   assign wr_word_s   = {pipe_tag_q[PIPE_LAT-1], tr_result};
   assign pop_s       = out_valid_q & out_ready;
   assign load_s      = ~out_valid_q | pop_s;
   assign mem_empty_s = (count_q == '0);
   assign mem_full_s  = (count_q == (AW+1)'(FIFO_DEPTH));
   assign mem_rd_s    = load_s & ~mem_empty_s;
   // An empty buffer hands the incoming word straight to the output register.
   assign mem_wr_s    = tr_output_ready & ~(load_s & mem_empty_s);

   // Result buffer storage and output register refill.
   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      out_tag_d   = out_tag_q;
      out_data_d  = out_data_q;
      if (mem_wr_s) begin
         mem_d[wr_ptr_q] = wr_word_s;
         wr_ptr_d        = wr_ptr_q + AW'(1'b1);
      end else begin
         wr_ptr_d        = wr_ptr_q;
      end
      if (load_s) begin
         if (!mem_empty_s) begin
            {out_tag_d, out_data_d} = mem_q[rd_ptr_q];
            out_valid_d             = 1'b1;
            rd_ptr_d                = rd_ptr_q + AW'(1'b1);
         end else if (tr_output_ready) begin
            {out_tag_d, out_data_d} = wr_word_s;
            out_valid_d             = 1'b1;
         end else begin
            out_valid_d             = 1'b0;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
      count_d = count_q + (AW+1)'(mem_wr_s) - (AW+1)'(mem_rd_s);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         credits_q   <= '0;
         rr_ptr_q    <= '0;
         tr_enable_q <= 1'b0;
         tr_l_v_q    <= 8'h00;
         tr_d_v_q    <= 16'h0000;
         issue_tag_q <= '0;
         pipe_vld_q  <= '0;
         for (int i = 0; i < PIPE_LAT; i++) pipe_tag_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_tag_q   <= '0;
         out_data_q  <= 56'h0;
         tag_error_q <= 1'b0;
      end else begin
         credits_q   <= credits_d;
         rr_ptr_q    <= rr_ptr_d;
         tr_enable_q <= tr_enable_d;
         tr_l_v_q    <= tr_l_v_d;
         tr_d_v_q    <= tr_d_v_d;
         issue_tag_q <= issue_tag_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_tag_q  <= pipe_tag_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_tag_q   <= out_tag_d;
         out_data_q  <= out_data_d;
         tag_error_q <= tag_error_d;
      end
   end

   // Buffer contents need no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef HUFF_ARB_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles where a lane waits for credit.
   always_comb begin
      if ((|req_valid) && !can_issue_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

   assign req_ready = grant_s;
   assign tr_enable = tr_enable_q;
   assign tr_l_V    = tr_l_v_q;
   assign tr_d_V    = tr_d_v_q;
   assign out_valid = out_valid_q;
   assign out_tag   = out_tag_q;
   assign out_data  = out_data_q;
   assign tag_error = tag_error_q;

   huffman_translation_arbiter_chk u_chk (
      .clk      (clk),
      .reset    (reset),
      .mem_wr   (mem_wr_s),
      .mem_full (mem_full_s)
   );

endmodule
